// File: rtl/crop_frame_scheduler_if.sv
// Handshake bundle between the crop scheduler, the ROI source, the crop filter and the pixel path.
// master = scheduler side, slave = surrounding environment.
interface crop_frame_scheduler_if #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10
);
  logic [IMG_ROW_BITWIDTH-1:0] roi_Y1_TDATA;
  logic [IMG_COL_BITWIDTH-1:0] roi_X1_TDATA;
  logic                        roi_TVALID;
  logic                        roi_TREADY;

  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA;
  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA;
  logic                        crop_Y1_TVALID;
  logic                        crop_X1_TVALID;
  logic                        crop_Y1_TREADY;
  logic                        crop_X1_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA;
  logic                        pixel_in_TVALID;
  logic                        pixel_in_TREADY;

  logic [PIXEL_BIT_WIDTH-1:0]  cf_pixel_TDATA;
  logic                        cf_pixel_TVALID;
  logic                        cf_pixel_TREADY;

  logic                        mon_TVALID;
  logic                        mon_TREADY;

  modport master (
    input  roi_Y1_TDATA, roi_X1_TDATA, roi_TVALID,
    output roi_TREADY,
    output crop_Y1_TDATA, crop_X1_TDATA, crop_Y1_TVALID, crop_X1_TVALID,
    input  crop_Y1_TREADY, crop_X1_TREADY,
    input  pixel_in_TDATA, pixel_in_TVALID,
    output pixel_in_TREADY,
    output cf_pixel_TDATA, cf_pixel_TVALID,
    input  cf_pixel_TREADY,
    input  mon_TVALID, mon_TREADY
  );

  modport slave (
    output roi_Y1_TDATA, roi_X1_TDATA, roi_TVALID,
    input  roi_TREADY,
    input  crop_Y1_TDATA, crop_X1_TDATA, crop_Y1_TVALID, crop_X1_TVALID,
    output crop_Y1_TREADY, crop_X1_TREADY,
    output pixel_in_TDATA, pixel_in_TVALID,
    input  pixel_in_TREADY,
    input  cf_pixel_TDATA, cf_pixel_TVALID,
    output cf_pixel_TREADY,
    output mon_TVALID, mon_TREADY
  );
endinterface

// File: rtl/crop_frame_scheduler.sv
// Per-frame scheduler: accepts a clamped ROI, hands coordinates to the crop filter, gates exactly
// one input frame of pixels through, then waits for the cropped output to drain (with timeout).
module crop_frame_scheduler #(
  parameter int PIXEL_BIT_WIDTH  = 12,
  parameter int IN_ROWS          = 40,
  parameter int IN_COLS          = 40,
  parameter int OUT_ROWS         = 20,
  parameter int OUT_COLS         = 20,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int DRAIN_TIMEOUT    = 1024,
  parameter int FRAME_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  crop_frame_scheduler_if.master     bus,
  output logic                       frame_done,
  output logic                       clamped,
  output logic                       timeout_err,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);
  localparam int IN_TOTAL  = IN_ROWS * IN_COLS;
  localparam int OUT_TOTAL = OUT_ROWS * OUT_COLS;
  localparam int CNT_W     = $clog2(IN_TOTAL + 1);
  localparam int IDLE_W    = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [IMG_ROW_BITWIDTH-1:0] Y_MAX     = IMG_ROW_BITWIDTH'(IN_ROWS - OUT_ROWS);
  localparam logic [IMG_COL_BITWIDTH-1:0] X_MAX     = IMG_COL_BITWIDTH'(IN_COLS - OUT_COLS);
  localparam logic [CNT_W-1:0]            IN_LAST   = CNT_W'(IN_TOTAL - 1);
  localparam logic [CNT_W-1:0]            OUT_FULL  = CNT_W'(OUT_TOTAL);
  localparam logic [IDLE_W-1:0]           IDLE_LAST = IDLE_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CFG, STREAM, DRAIN, DONE} state_t;

  state_t                      state;
  logic [IMG_ROW_BITWIDTH-1:0] y1;
  logic [IMG_COL_BITWIDTH-1:0] x1;
  logic                        crop_y_vld;
  logic                        crop_x_vld;
  logic [CNT_W-1:0]            in_cnt;
  logic [CNT_W-1:0]            out_cnt;
  logic [IDLE_W-1:0]           idle_cnt;

  logic [IMG_ROW_BITWIDTH-1:0] y_clip;
  logic [IMG_COL_BITWIDTH-1:0] x_clip;
  logic [CNT_W-1:0]            out_cnt_nxt;
  logic [PIXEL_BIT_WIDTH-1:0]  pix;
  logic                        in_stream;
  logic                        pix_hs;
  logic                        mon_hs;
  logic                        y_done;
  logic                        x_done;

  // Pixel gate is combinational so the stream passes with zero latency; reset forces it shut.
  assign in_stream           = (state == STREAM) && reset;
  assign pix                 = bus.pixel_in_TDATA;
  assign bus.cf_pixel_TDATA  = pix;
  assign bus.cf_pixel_TVALID = in_stream && bus.pixel_in_TVALID;
  assign bus.pixel_in_TREADY = in_stream && bus.cf_pixel_TREADY;
  assign bus.roi_TREADY      = (state == IDLE) && reset;
  assign bus.crop_Y1_TDATA   = y1;
  assign bus.crop_X1_TDATA   = x1;
  assign bus.crop_Y1_TVALID  = crop_y_vld;
  assign bus.crop_X1_TVALID  = crop_x_vld;

  assign pix_hs = bus.cf_pixel_TVALID && bus.cf_pixel_TREADY;
  assign mon_hs = bus.mon_TVALID && bus.mon_TREADY && ((state == STREAM) || (state == DRAIN));
  assign y_done = !crop_y_vld || bus.crop_Y1_TREADY;
  assign x_done = !crop_x_vld || bus.crop_X1_TREADY;

  always_comb begin
    y_clip      = (bus.roi_Y1_TDATA > Y_MAX) ? Y_MAX : bus.roi_Y1_TDATA;
    x_clip      = (bus.roi_X1_TDATA > X_MAX) ? X_MAX : bus.roi_X1_TDATA;
    out_cnt_nxt = out_cnt;
    // Saturate at a full output frame; extra beats carry no information.
    if (mon_hs && (out_cnt < OUT_FULL)) out_cnt_nxt = out_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      y1          <= '0;
      x1          <= '0;
      crop_y_vld  <= 1'b0;
      crop_x_vld  <= 1'b0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      idle_cnt    <= '0;
      frame_done  <= 1'b0;
      clamped     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      clamped    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.roi_TVALID) begin
            y1         <= y_clip;
            x1         <= x_clip;
            clamped    <= (y_clip != bus.roi_Y1_TDATA) || (x_clip != bus.roi_X1_TDATA);
            crop_y_vld <= 1'b1;
            crop_x_vld <= 1'b1;
            state      <= CFG;
          end
        end
        CFG: begin
          if (bus.crop_Y1_TREADY) crop_y_vld <= 1'b0;
          if (bus.crop_X1_TREADY) crop_x_vld <= 1'b0;
          if (y_done && x_done) state <= STREAM;
        end
        STREAM: begin
          out_cnt <= out_cnt_nxt;
          if (pix_hs) begin
            if (in_cnt == IN_LAST) begin
              in_cnt   <= '0;
              idle_cnt <= '0;
              state    <= DRAIN;
            end else begin
              in_cnt <= in_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          out_cnt <= out_cnt_nxt;
          if (out_cnt_nxt >= OUT_FULL) begin
            frame_done <= 1'b1;
            idle_cnt   <= '0;
            state      <= DONE;
          end else if (mon_hs) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_LAST) begin
            timeout_err <= 1'b1;
            in_cnt      <= '0;
            out_cnt     <= '0;
            idle_cnt    <= '0;
            state       <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        DONE: begin
          frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
          out_cnt     <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crop_frame_scheduler.sv
// Directed bench for crop_frame_scheduler: one task per scenario, default 40x40 -> 20x20 geometry.
module tb_crop_frame_scheduler;
  localparam int PW = 12;
  localparam int RW = 10;
  localparam int CW = 10;
  localparam int FW = 16;

  logic          clk;
  logic          reset;
  logic          frame_done;
  logic          clamped;
  logic          timeout_err;
  logic [FW-1:0] frame_count;
  int            errors;
  int            checks;

  crop_frame_scheduler_if #(.PIXEL_BIT_WIDTH(PW), .IMG_ROW_BITWIDTH(RW), .IMG_COL_BITWIDTH(CW)) bus ();

  crop_frame_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_done  (frame_done),
    .clamped     (clamped),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_roi(input logic [RW-1:0] y, input logic [CW-1:0] x);
    bus.roi_Y1_TDATA = y;
    bus.roi_X1_TDATA = x;
    bus.roi_TVALID   = 1'b1;
    tick();
    bus.roi_TVALID   = 1'b0;
  endtask

  task automatic cfg_fast();
    bus.crop_Y1_TREADY = 1'b1;
    bus.crop_X1_TREADY = 1'b1;
    tick();
    bus.crop_Y1_TREADY = 1'b0;
    bus.crop_X1_TREADY = 1'b0;
  endtask

  task automatic mon_beats(input int n);
    bus.mon_TVALID = 1'b1;
    bus.mon_TREADY = 1'b1;
    repeat (n) tick();
    bus.mon_TVALID = 1'b0;
    bus.mon_TREADY = 1'b0;
  endtask

  task automatic stream_pixels(input int n, input bit stall, input int mon_n,
                               output int accepted, output int data_bad, output int cycles);
    int mon_sent;
    accepted = 0; data_bad = 0; cycles = 0; mon_sent = 0;
    while (accepted < n && cycles < n * 8 + 100) begin
      bus.pixel_in_TVALID = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.cf_pixel_TREADY = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pixel_in_TDATA  = PW'(accepted * 7 + 3);
      bus.mon_TVALID      = (mon_sent < mon_n);
      bus.mon_TREADY      = (mon_sent < mon_n);
      #1;
      if (bus.cf_pixel_TDATA !== bus.pixel_in_TDATA || bus.cf_pixel_TVALID !== bus.pixel_in_TVALID ||
          bus.pixel_in_TREADY !== bus.cf_pixel_TREADY) data_bad++;
      if (bus.pixel_in_TVALID && bus.pixel_in_TREADY) accepted++;
      if (bus.mon_TVALID) mon_sent++;
      cycles++;
      tick();
    end
    bus.pixel_in_TVALID = 1'b0;
    bus.cf_pixel_TREADY = 1'b0;
    bus.mon_TVALID      = 1'b0;
    bus.mon_TREADY      = 1'b0;
  endtask

  task automatic finish_frame();
    int acc, bad, cyc;
    cfg_fast();
    stream_pixels(1600, 1'b0, 0, acc, bad, cyc);
    mon_beats(400);
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.crop_Y1_TVALID !== 1'b0 || bus.crop_X1_TVALID !== 1'b0) begin errors++;
      $display("FAIL rst_crop_vld: got %b/%b expected 0/0", bus.crop_Y1_TVALID, bus.crop_X1_TVALID); end
    checks++; if (bus.crop_Y1_TDATA !== 10'd0 || bus.crop_X1_TDATA !== 10'd0) begin errors++;
      $display("FAIL rst_crop_data: got %0d/%0d expected 0/0", bus.crop_Y1_TDATA, bus.crop_X1_TDATA); end
    checks++; if (frame_done !== 1'b0 || clamped !== 1'b0 || timeout_err !== 1'b0) begin errors++;
      $display("FAIL rst_flags: got %b%b%b expected 000", frame_done, clamped, timeout_err); end
    checks++; if (frame_count !== 16'd0) begin errors++;
      $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
    bus.pixel_in_TVALID = 1'b1;
    bus.cf_pixel_TREADY = 1'b1;
    #1;
    checks++; if (bus.pixel_in_TREADY !== 1'b0 || bus.cf_pixel_TVALID !== 1'b0) begin errors++;
      $display("FAIL rst_pixel_gate: got %b/%b expected 0/0", bus.pixel_in_TREADY, bus.cf_pixel_TVALID); end
    bus.pixel_in_TVALID = 1'b0;
    bus.cf_pixel_TREADY = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (bus.roi_TREADY !== 1'b1) begin errors++;
      $display("FAIL rst_roi_ready: got %b expected 1", bus.roi_TREADY); end
  endtask

  task automatic test_basic();
    int acc, bad, cyc, fd;
    mon_beats(10);
    send_roi(10'd5, 10'd7);
    checks++; if (bus.crop_Y1_TDATA !== 10'd5 || bus.crop_X1_TDATA !== 10'd7) begin errors++;
      $display("FAIL basic_coords: got %0d/%0d expected 5/7", bus.crop_Y1_TDATA, bus.crop_X1_TDATA); end
    checks++; if (bus.crop_Y1_TVALID !== 1'b1 || bus.crop_X1_TVALID !== 1'b1) begin errors++;
      $display("FAIL basic_crop_vld: got %b/%b expected 1/1", bus.crop_Y1_TVALID, bus.crop_X1_TVALID); end
    checks++; if (clamped !== 1'b0 || bus.roi_TREADY !== 1'b0) begin errors++;
      $display("FAIL basic_clamp_ready: got clamped=%b roi_ready=%b expected 0/0", clamped, bus.roi_TREADY); end
    cfg_fast();
    checks++; if (bus.crop_Y1_TVALID !== 1'b0 || bus.crop_X1_TVALID !== 1'b0) begin errors++;
      $display("FAIL basic_crop_drop: got %b/%b expected 0/0", bus.crop_Y1_TVALID, bus.crop_X1_TVALID); end
    stream_pixels(1600, 1'b0, 0, acc, bad, cyc);
    checks++; if (acc !== 1600 || cyc !== 1600 || bad !== 0) begin errors++;
      $display("FAIL basic_stream: got acc=%0d cyc=%0d bad=%0d expected 1600/1600/0", acc, cyc, bad); end
    mon_beats(399);
    checks++; if (frame_done !== 1'b0) begin errors++;
      $display("FAIL basic_early_done: got %b expected 0 after 399 beats", frame_done); end
    mon_beats(1);
    fd = 0;
    for (int i = 0; i < 4; i++) begin
      if (frame_done === 1'b1) fd++;
      tick();
    end
    checks++; if (fd !== 1) begin errors++;
      $display("FAIL basic_done_pulse: got %0d cycles expected 1", fd); end
    checks++; if (frame_count !== 16'd1 || bus.roi_TREADY !== 1'b1) begin errors++;
      $display("FAIL basic_count: got %0d ready=%b expected 1 ready=1", frame_count, bus.roi_TREADY); end
  endtask

  task automatic test_clamp();
    send_roi(10'd35, 10'd30);
    checks++; if (bus.crop_Y1_TDATA !== 10'd20 || bus.crop_X1_TDATA !== 10'd20) begin errors++;
      $display("FAIL clamp_coords: got %0d/%0d expected 20/20", bus.crop_Y1_TDATA, bus.crop_X1_TDATA); end
    checks++; if (clamped !== 1'b1) begin errors++;
      $display("FAIL clamp_pulse: got %b expected 1", clamped); end
    tick();
    checks++; if (clamped !== 1'b0) begin errors++;
      $display("FAIL clamp_single: got %b expected 0", clamped); end
    finish_frame();
    checks++; if (frame_count !== 16'd2) begin errors++;
      $display("FAIL clamp_count: got %0d expected 2", frame_count); end
    send_roi(10'd20, 10'd21);
    checks++; if (bus.crop_Y1_TDATA !== 10'd20 || bus.crop_X1_TDATA !== 10'd20 || clamped !== 1'b1) begin errors++;
      $display("FAIL clamp_x_only: got %0d/%0d clamped=%b expected 20/20 clamped=1",
               bus.crop_Y1_TDATA, bus.crop_X1_TDATA, clamped); end
    finish_frame();
    checks++; if (frame_count !== 16'd3) begin errors++;
      $display("FAIL clamp_count2: got %0d expected 3", frame_count); end
  endtask

  task automatic test_cfg_stall();
    int acc, bad, cyc;
    send_roi(10'd20, 10'd20);
    checks++; if (clamped !== 1'b0 || bus.crop_Y1_TDATA !== 10'd20 || bus.crop_X1_TDATA !== 10'd20) begin errors++;
      $display("FAIL cfg_edge_roi: got %0d/%0d clamped=%b expected 20/20 clamped=0",
               bus.crop_Y1_TDATA, bus.crop_X1_TDATA, clamped); end
    bus.crop_Y1_TREADY = 1'b1;
    tick();
    bus.crop_Y1_TREADY = 1'b0;
    bus.pixel_in_TVALID = 1'b1;
    bus.cf_pixel_TREADY = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.pixel_in_TREADY !== 1'b0 || bus.cf_pixel_TVALID !== 1'b0 || bus.crop_Y1_TVALID !== 1'b0 ||
          bus.crop_X1_TVALID !== 1'b1 || bus.crop_X1_TDATA !== 10'd20) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL cfg_wait_x: got %0d bad cycles expected 0", bad); end
    bus.crop_X1_TREADY = 1'b1;
    tick();
    bus.crop_X1_TREADY = 1'b0;
    #1;
    checks++; if (bus.crop_X1_TVALID !== 1'b0 || bus.pixel_in_TREADY !== 1'b1) begin errors++;
      $display("FAIL cfg_enter_stream: got xvld=%b pix_ready=%b expected 0/1", bus.crop_X1_TVALID, bus.pixel_in_TREADY); end
    stream_pixels(1600, 1'b0, 0, acc, bad, cyc);
    mon_beats(400);
    tick();
    tick();
    checks++; if (acc !== 1600 || bad !== 0 || frame_count !== 16'd4) begin errors++;
      $display("FAIL cfg_frame: got acc=%0d bad=%0d count=%0d expected 1600/0/4", acc, bad, frame_count); end
  endtask

  task automatic test_stalls();
    int acc, bad, cyc, bad2;
    send_roi(10'd0, 10'd0);
    cfg_fast();
    stream_pixels(1600, 1'b1, 200, acc, bad, cyc);
    checks++; if (acc !== 1600 || bad !== 0) begin errors++;
      $display("FAIL stall_stream: got acc=%0d bad=%0d expected 1600/0", acc, bad); end
    bus.pixel_in_TVALID = 1'b1;
    bus.cf_pixel_TREADY = 1'b1;
    bad2 = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.pixel_in_TREADY !== 1'b0 || bus.cf_pixel_TVALID !== 1'b0) bad2++;
      tick();
    end
    bus.pixel_in_TVALID = 1'b0;
    bus.cf_pixel_TREADY = 1'b0;
    checks++; if (bad2 !== 0) begin errors++;
      $display("FAIL stall_pixel_1601: got %0d accepting cycles expected 0", bad2); end
    mon_beats(199);
    checks++; if (frame_done !== 1'b0) begin errors++;
      $display("FAIL stall_early_done: got %b expected 0", frame_done); end
    mon_beats(1);
    checks++; if (frame_done !== 1'b1) begin errors++;
      $display("FAIL stall_done: got %b expected 1", frame_done); end
    tick();
    tick();
    checks++; if (frame_count !== 16'd5) begin errors++;
      $display("FAIL stall_count: got %0d expected 5", frame_count); end
  endtask

  task automatic test_timeout();
    int acc, bad, cyc, n, fd;
    send_roi(10'd1, 10'd1);
    cfg_fast();
    stream_pixels(1600, 1'b0, 0, acc, bad, cyc);
    mon_beats(399);
    n = 0; fd = 0;
    while (timeout_err !== 1'b1 && n < 1100) begin
      tick();
      n++;
      if (frame_done === 1'b1) fd = 1;
    end
    checks++; if (n !== 1024 || timeout_err !== 1'b1) begin errors++;
      $display("FAIL timeout_cycles: got %0d err=%b expected 1024 err=1", n, timeout_err); end
    checks++; if (fd !== 0 || frame_count !== 16'd5 || bus.roi_TREADY !== 1'b1) begin errors++;
      $display("FAIL timeout_state: got done=%0d count=%0d ready=%b expected 0/5/1", fd, frame_count, bus.roi_TREADY); end
    send_roi(10'd2, 10'd3);
    checks++; if (bus.crop_Y1_TDATA !== 10'd2 || bus.crop_X1_TDATA !== 10'd3 || bus.crop_Y1_TVALID !== 1'b1) begin errors++;
      $display("FAIL timeout_next_roi: got %0d/%0d vld=%b expected 2/3 vld=1",
               bus.crop_Y1_TDATA, bus.crop_X1_TDATA, bus.crop_Y1_TVALID); end
    finish_frame();
    checks++; if (frame_count !== 16'd6 || timeout_err !== 1'b1) begin errors++;
      $display("FAIL timeout_sticky: got count=%0d err=%b expected 6/1", frame_count, timeout_err); end
  endtask

  task automatic test_mid_reset();
    int acc, bad, cyc;
    send_roi(10'd4, 10'd4);
    cfg_fast();
    stream_pixels(800, 1'b0, 100, acc, bad, cyc);
    bus.pixel_in_TVALID = 1'b1;
    bus.cf_pixel_TREADY = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (bus.pixel_in_TREADY !== 1'b0 || bus.cf_pixel_TVALID !== 1'b0) begin errors++;
      $display("FAIL mid_rst_gate: got %b/%b expected 0/0", bus.pixel_in_TREADY, bus.cf_pixel_TVALID); end
    tick();
    checks++; if (bus.crop_Y1_TVALID !== 1'b0 || bus.crop_X1_TVALID !== 1'b0 ||
                  bus.crop_Y1_TDATA !== 10'd0 || bus.crop_X1_TDATA !== 10'd0) begin errors++;
      $display("FAIL mid_rst_crop: got vld %b/%b data %0d/%0d expected 0/0 0/0", bus.crop_Y1_TVALID,
               bus.crop_X1_TVALID, bus.crop_Y1_TDATA, bus.crop_X1_TDATA); end
    checks++; if (frame_done !== 1'b0 || clamped !== 1'b0 || timeout_err !== 1'b0 || frame_count !== 16'd0) begin errors++;
      $display("FAIL mid_rst_flags: got done=%b clamp=%b err=%b count=%0d expected 0/0/0/0",
               frame_done, clamped, timeout_err, frame_count); end
    bus.pixel_in_TVALID = 1'b0;
    bus.cf_pixel_TREADY = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (bus.roi_TREADY !== 1'b1) begin errors++;
      $display("FAIL mid_rst_idle: got %b expected 1", bus.roi_TREADY); end
    send_roi(10'd6, 10'd6);
    finish_frame();
    checks++; if (frame_count !== 16'd1) begin errors++;
      $display("FAIL mid_rst_frame: got %0d expected 1", frame_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.roi_Y1_TDATA    = '0;
    bus.roi_X1_TDATA    = '0;
    bus.roi_TVALID      = 1'b0;
    bus.crop_Y1_TREADY  = 1'b0;
    bus.crop_X1_TREADY  = 1'b0;
    bus.pixel_in_TDATA  = '0;
    bus.pixel_in_TVALID = 1'b0;
    bus.cf_pixel_TREADY = 1'b0;
    bus.mon_TVALID      = 1'b0;
    bus.mon_TREADY      = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_cfg_stall();
    test_stalls();
    test_timeout();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
